// File: rtl/bringup_spinner_multi.sv
`default_nettype none
// ============================================================================
// Module      : bringup_spinner_multi
// Description : Bringup LED/pin pattern generator. A PATTERN_BITS-wide pattern
//               register rotates right or left, holds, or "breathes" (PWM
//               dimming with a triangle duty sweep) once per PERIOD clocks.
//               A valid/ready port loads a new pattern at runtime. The tick
//               output pulses once per period and doubles as a scope trigger.
// Ports       : clk_12mhz    in   system clock
//               reset_n      in   asynchronous assert, synchronous release,
//                                 active-low
//               mode         in   0=ROTR 1=ROTL 2=HOLD 3=BREATHE
//               load_valid   in   pattern load request
//               load_pattern in   pattern to load (ignored unless accepted)
//               load_ready   out  low for one cycle after each accept
//               out          out  registered drive, out[i] follows pattern[i]
//               pattern      out  current pattern register
//               tick         out  one-cycle pulse at every period boundary
// Revision    : 1.0 - initial release
// ============================================================================
module bringup_spinner_multi #(
    parameter int unsigned                PERIOD        = 1200000,
    parameter int unsigned                PATTERN_BITS  = 8,
    parameter int unsigned                NUM_OUT       = 2,
    parameter logic [PATTERN_BITS-1:0]    RESET_PATTERN = 8'b00111011,
    parameter int unsigned                PWM_BITS      = 4
) (
    input  logic                    clk_12mhz,
    input  logic                    reset_n,
    input  logic [1:0]              mode,
    input  logic                    load_valid,
    input  logic [PATTERN_BITS-1:0] load_pattern,
    output logic                    load_ready,
    output logic [NUM_OUT-1:0]      out,
    output logic [PATTERN_BITS-1:0] pattern,
    output logic                    tick
);

    localparam int unsigned CNT_W = $clog2(PERIOD);

    localparam logic [1:0] c_MODE_ROTR    = 2'd0;
    localparam logic [1:0] c_MODE_ROTL    = 2'd1;
    localparam logic [1:0] c_MODE_HOLD    = 2'd2;
    localparam logic [1:0] c_MODE_BREATHE = 2'd3;

    localparam logic [CNT_W-1:0]    c_CNT_RELOAD = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE    = CNT_W'(1);
    localparam logic [PWM_BITS-1:0] c_PWM_ONE    = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] c_DUTY_MAX   = '1;

    // Breathe sweep direction
    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [PATTERN_BITS-1:0] pattern_q, pattern_d;
    logic [PWM_BITS-1:0]     duty_q,    duty_d;
    logic                    dir_q,     dir_d;
    logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic                    tick_q,    tick_d;
    logic [NUM_OUT-1:0]      out_q,     out_d;
    logic                    ready_q,   ready_d;

    logic w_accept;
    logic w_period_end;
    logic w_tick_evt;
    logic w_pwm_on;
    logic w_gate;

    assign w_accept     = load_valid & ready_q;
    assign w_period_end = (cnt_q == '0);
    // A load restarts the period, so it swallows a coincident boundary.
    assign w_tick_evt   = w_period_end & ~w_accept;
    assign w_pwm_on     = (pwm_cnt_q < duty_q);
    // Gating follows the live mode input so dimming engages without waiting
    // for a tick; only the pattern/duty updates are tick-aligned.
    assign w_gate       = (mode == c_MODE_BREATHE) ? w_pwm_on : 1'b1;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q - c_CNT_ONE;
        pattern_d = pattern_q;
        duty_d    = duty_q;
        dir_d     = dir_q;
        pwm_cnt_d = pwm_cnt_q + c_PWM_ONE;
        tick_d    = w_tick_evt;
        ready_d   = ~w_accept;
        out_d     = pattern_q[NUM_OUT-1:0] & {NUM_OUT{w_gate}};

        if (w_accept || w_period_end) begin
            cnt_d = c_CNT_RELOAD;
        end

        if (w_accept) begin
            pattern_d = load_pattern;
        end else if (w_tick_evt) begin
            case (mode)
                c_MODE_ROTR: pattern_d = {pattern_q[0], pattern_q[PATTERN_BITS-1:1]};
                c_MODE_ROTL: pattern_d = {pattern_q[PATTERN_BITS-2:0], pattern_q[PATTERN_BITS-1]};
                c_MODE_HOLD: pattern_d = pattern_q;
                c_MODE_BREATHE: begin
                    // Triangle sweep with no dwell: the end-point tick both
                    // flips direction and takes the first step back.
                    if (dir_q == c_DIR_UP) begin
                        if (duty_q == c_DUTY_MAX) begin
                            dir_d  = c_DIR_DOWN;
                            duty_d = duty_q - c_PWM_ONE;
                        end else begin
                            duty_d = duty_q + c_PWM_ONE;
                        end
                    end else begin
                        if (duty_q == '0) begin
                            dir_d  = c_DIR_UP;
                            duty_d = duty_q + c_PWM_ONE;
                        end else begin
                            duty_d = duty_q - c_PWM_ONE;
                        end
                    end
                end
                default: pattern_d = pattern_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= c_CNT_RELOAD;
            pattern_q <= RESET_PATTERN;
            duty_q    <= '0;
            dir_q     <= c_DIR_UP;
            pwm_cnt_q <= '0;
            tick_q    <= 1'b0;
            out_q     <= '0;
            ready_q   <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            pwm_cnt_q <= pwm_cnt_d;
            tick_q    <= tick_d;
            out_q     <= out_d;
            ready_q   <= ready_d;
        end
    end

    assign load_ready = ready_q;
    assign out        = out_q;
    assign pattern    = pattern_q;
    assign tick       = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_bringup_spinner_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_bringup_spinner_multi
// Description : Self-checking bench for bringup_spinner_multi with PERIOD=4,
//               PATTERN_BITS=8, NUM_OUT=2, PWM_BITS=2. Expected patterns and
//               breathe duties are queued as stimulus is applied and popped
//               at each expected tick. Outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bringup_spinner_multi;

    logic       clk_12mhz = 1'b0;
    logic       reset_n;
    logic [1:0] mode;
    logic       load_valid;
    logic [7:0] load_pattern;
    logic       load_ready;
    logic [1:0] out;
    logic [7:0] pattern;
    logic       tick;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_pat_q[$];
    int         exp_duty_q[$];

    always #5 clk_12mhz = ~clk_12mhz;

    bringup_spinner_multi #(
        .PERIOD        (4),
        .PATTERN_BITS  (8),
        .NUM_OUT       (2),
        .RESET_PATTERN (8'h3B),
        .PWM_BITS      (2)
    ) dut (
        .clk_12mhz    (clk_12mhz),
        .reset_n      (reset_n),
        .mode         (mode),
        .load_valid   (load_valid),
        .load_pattern (load_pattern),
        .load_ready   (load_ready),
        .out          (out),
        .pattern      (pattern),
        .tick         (tick)
    );

    // Reset pulse; returns on the falling edge where reset_n was released
    // ("cycle 0"). Rising edge k after that is cycle k.
    task automatic do_reset(input logic [1:0] m);
        @(negedge clk_12mhz);
        reset_n      = 1'b0;
        mode         = m;
        load_valid   = 1'b0;
        load_pattern = 8'h00;
        @(negedge clk_12mhz);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_12mhz);
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
        total++; if (out !== 2'b00) begin bad++; $display("FAIL reset_out: got %b want 00", out); end
        total++; if (pattern !== 8'h3B) begin bad++; $display("FAIL reset_pattern: got %h want 3b", pattern); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", load_ready); end
    endtask

    task automatic test_rotr();
        logic [7:0] exp_pat;
        logic [7:0] prev_pat;
        logic       exp_tick;
        exp_pat_q = {};
        exp_pat_q.push_back(8'h9D);
        exp_pat_q.push_back(8'hCE);
        exp_pat_q.push_back(8'h67);
        do_reset(2'd0);
        exp_pat  = 8'h3B;
        prev_pat = 8'h3B;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_12mhz);
            exp_tick = (k % 4 == 0);
            total++; if (tick !== exp_tick) begin bad++; $display("FAIL rotr_tick c%0d: got %b want %b", k, tick, exp_tick); end
            if (exp_tick) begin
                if (exp_pat_q.size() == 0) begin
                    total++; bad++; $display("FAIL rotr_queue c%0d: got empty want entry", k);
                end else begin
                    exp_pat = exp_pat_q.pop_front();
                end
            end
            total++; if (pattern !== exp_pat) begin bad++; $display("FAIL rotr_pattern c%0d: got %h want %h", k, pattern, exp_pat); end
            total++; if (out !== prev_pat[1:0]) begin bad++; $display("FAIL rotr_out c%0d: got %b want %b", k, out, prev_pat[1:0]); end
            prev_pat = exp_pat;
        end
    endtask

    task automatic test_rotl_hold();
        logic [7:0] exp_pat;
        logic [7:0] prev_pat;
        logic       exp_tick;
        exp_pat_q = {};
        exp_pat_q.push_back(8'h76);
        exp_pat_q.push_back(8'hEC);
        exp_pat_q.push_back(8'hD9);
        do_reset(2'd1);
        exp_pat  = 8'h3B;
        prev_pat = 8'h3B;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_12mhz);
            exp_tick = (k % 4 == 0);
            total++; if (tick !== exp_tick) begin bad++; $display("FAIL rotl_tick c%0d: got %b want %b", k, tick, exp_tick); end
            if (exp_tick && k <= 12) begin
                if (exp_pat_q.size() == 0) begin
                    total++; bad++; $display("FAIL rotl_queue c%0d: got empty want entry", k);
                end else begin
                    exp_pat = exp_pat_q.pop_front();
                end
            end
            total++; if (pattern !== exp_pat) begin bad++; $display("FAIL rotl_pattern c%0d: got %h want %h", k, pattern, exp_pat); end
            total++; if (out !== prev_pat[1:0]) begin bad++; $display("FAIL rotl_out c%0d: got %b want %b", k, out, prev_pat[1:0]); end
            prev_pat = exp_pat;
            if (k == 12) mode = 2'd2;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_pat;
        exp_pat_q = {};
        do_reset(2'd2);
        repeat (2) @(negedge clk_12mhz);
        load_valid   = 1'b1;
        load_pattern = 8'h81;
        exp_pat_q.push_back(8'h81);
        @(negedge clk_12mhz); // cycle 3: first accept landed
        exp_pat = exp_pat_q.pop_front();
        total++; if (pattern !== exp_pat) begin bad++; $display("FAIL b2b_first pattern: got %h want %h", pattern, exp_pat); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_low: got %b want 0", load_ready); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL b2b_tick3: got %b want 0", tick); end
        load_pattern = 8'h42;
        exp_pat_q.push_back(8'h42);
        @(negedge clk_12mhz); // cycle 4: not ready, 42 ignored; period restarted
        total++; if (pattern !== exp_pat) begin bad++; $display("FAIL b2b_ignored pattern: got %h want %h", pattern, exp_pat); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_high: got %b want 1", load_ready); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL b2b_tick4: got %b want 0", tick); end
        @(negedge clk_12mhz); // cycle 5: second accept
        exp_pat = exp_pat_q.pop_front();
        total++; if (pattern !== exp_pat) begin bad++; $display("FAIL b2b_second pattern: got %h want %h", pattern, exp_pat); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_low2: got %b want 0", load_ready); end
        load_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk_12mhz);
            total++; if (tick !== (j == 4)) begin bad++; $display("FAIL b2b_tick_after j%0d: got %b want %b", j, tick, (j == 4)); end
            total++; if (pattern !== exp_pat) begin bad++; $display("FAIL b2b_hold j%0d: got %h want %h", j, pattern, exp_pat); end
        end
    endtask

    task automatic test_load_at_tick();
        logic [7:0] exp_pat;
        exp_pat_q = {};
        do_reset(2'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_12mhz);
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL lat_pre_tick c%0d: got %b want 0", k, tick); end
        end
        // counter is 0 now: the load must win over the boundary
        load_valid   = 1'b1;
        load_pattern = 8'h5A;
        exp_pat_q.push_back(8'h5A);
        exp_pat_q.push_back(8'h2D);
        @(negedge clk_12mhz);
        exp_pat = exp_pat_q.pop_front();
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL lat_suppressed tick: got %b want 0", tick); end
        total++; if (pattern !== exp_pat) begin bad++; $display("FAIL lat_pattern: got %h want %h", pattern, exp_pat); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL lat_ready: got %b want 0", load_ready); end
        load_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk_12mhz);
            total++; if (tick !== (j == 4)) begin bad++; $display("FAIL lat_tick j%0d: got %b want %b", j, tick, (j == 4)); end
            if (j == 4) exp_pat = exp_pat_q.pop_front();
            total++; if (pattern !== exp_pat) begin bad++; $display("FAIL lat_rot j%0d: got %h want %h", j, pattern, exp_pat); end
        end
    endtask

    task automatic test_breathe();
        int   cur;
        int   c0;
        int   c1;
        logic exp_tick;
        exp_duty_q = {};
        exp_duty_q.push_back(1);
        exp_duty_q.push_back(2);
        exp_duty_q.push_back(3);
        exp_duty_q.push_back(2);
        exp_duty_q.push_back(1);
        exp_duty_q.push_back(0);
        exp_duty_q.push_back(1);
        exp_duty_q.push_back(2);
        do_reset(2'd3);
        load_valid   = 1'b1;
        load_pattern = 8'hFF;
        @(negedge clk_12mhz); // cycle 1: accepted, period restarted
        total++; if (pattern !== 8'hFF) begin bad++; $display("FAIL br_load pattern: got %h want ff", pattern); end
        load_valid = 1'b0;
        cur = 0; c0 = 0; c1 = 0;
        for (int k = 2; k <= 33; k++) begin
            @(negedge clk_12mhz);
            exp_tick = (k >= 5) && ((k - 5) % 4 == 0);
            total++; if (tick !== exp_tick) begin bad++; $display("FAIL br_tick c%0d: got %b want %b", k, tick, exp_tick); end
            c0 += (out[0] === 1'b1) ? 1 : 0;
            c1 += (out[1] === 1'b1) ? 1 : 0;
            if (exp_tick) begin
                total++; if (c0 != cur) begin bad++; $display("FAIL br_duty0 c%0d: got %0d high want %0d", k, c0, cur); end
                total++; if (c1 != cur) begin bad++; $display("FAIL br_duty1 c%0d: got %0d high want %0d", k, c1, cur); end
                total++; if (pattern !== 8'hFF) begin bad++; $display("FAIL br_pattern c%0d: got %h want ff", k, pattern); end
                if (exp_duty_q.size() == 0) begin
                    total++; bad++; $display("FAIL br_queue c%0d: got empty want entry", k);
                end else begin
                    cur = exp_duty_q.pop_front();
                end
                c0 = 0; c1 = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2'd3);
        load_valid   = 1'b1;
        load_pattern = 8'hFF;
        @(negedge clk_12mhz);
        load_valid = 1'b0;
        for (int k = 2; k <= 9; k++) @(negedge clk_12mhz);
        // duty is 2 here; a load lands on the next edge
        load_valid   = 1'b1;
        load_pattern = 8'h55;
        @(negedge clk_12mhz);
        total++; if (pattern !== 8'h55) begin bad++; $display("FAIL rm_pre pattern: got %h want 55", pattern); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rm_pre ready: got %b want 0", load_ready); end
        total++; if (out !== 2'b11) begin bad++; $display("FAIL rm_pre out: got %b want 11", out); end
        #1 reset_n = 1'b0;
        #1;
        total++; if (out !== 2'b00) begin bad++; $display("FAIL rm_async out: got %b want 00", out); end
        total++; if (pattern !== 8'h3B) begin bad++; $display("FAIL rm_async pattern: got %h want 3b", pattern); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL rm_async ready: got %b want 1", load_ready); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL rm_async tick: got %b want 0", tick); end
        @(negedge clk_12mhz);
        mode       = 2'd0;
        load_valid = 1'b0;
        reset_n    = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_12mhz);
            total++; if (tick !== (k == 4)) begin bad++; $display("FAIL rm_tick c%0d: got %b want %b", k, tick, (k == 4)); end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        mode         = 2'd0;
        load_valid   = 1'b0;
        load_pattern = 8'h00;
        test_reset();
        test_rotr();
        test_rotl_hold();
        test_back_to_back();
        test_load_at_tick();
        test_breathe();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
